// File: rtl/fifo_parity_checker.sv
// fifo_parity_checker: pops parity-tagged words, drops and counts bad ones, forwards good payloads via a 2-entry buffer.
// Optional macro PARITY_CHK_HALT_EN stops input flow after a bad word until clr_err_i.
module fifo_parity_checker #(
   parameter int DATA_WIDTH    = 8,
   parameter int ODD_PARITY    = 0,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid_i,
   input  logic [DATA_WIDTH:0]      in_data_i,
   output logic                     in_grant_o,
   output logic                     out_valid_o,
   output logic [DATA_WIDTH-1:0]    out_data_o,
   input  logic                     out_grant_i,
   output logic                     err_o,
   output logic [ERR_CNT_WIDTH-1:0] err_count_o,
   input  logic                     clr_err_i
);
   logic [DATA_WIDTH-1:0]    b1, s0, s1;
   logic [1:0]               count, count_n;
   logic [ERR_CNT_WIDTH-1:0] cnt_base, cnt_n;
   logic                     acc, push, bad, pop, wr0, wr1, run_ok;
   // out_data_o is the head entry itself; b1 is the second slot
   always_comb begin
      acc      = in_valid_i && in_grant_o;
      push     = acc && ((^in_data_i) == (ODD_PARITY != 0));
      bad      = acc && !push;
      pop      = out_valid_o && out_grant_i;
      count_n  = count + {1'b0, push} - {1'b0, pop};
      wr0      = push && (count == {1'b0, pop});
      wr1      = push && !wr0;
      s0       = wr0 ? in_data_i[DATA_WIDTH-1:0] : (pop ? b1 : out_data_o);
      s1       = wr1 ? in_data_i[DATA_WIDTH-1:0] : b1;
      cnt_base = clr_err_i ? '0 : err_count_o;
      cnt_n    = (bad && cnt_base != '1) ? cnt_base + ERR_CNT_WIDTH'(1) : cnt_base;
   end
`ifdef PARITY_CHK_HALT_EN
   typedef enum logic {RUN, HALT} state_t;
   state_t state, state_n;
   // grant needs RUN both now and next, so leaving HALT costs one extra cycle
   always_comb begin
      state_n = bad ? HALT : (clr_err_i ? RUN : state);
      run_ok  = (state == RUN) && (state_n == RUN);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= RUN;
      else          state <= state_n;
`else
   always_comb run_ok = 1'b1;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count       <= '0;
         out_data_o  <= '0;
         b1          <= '0;
         out_valid_o <= 1'b0;
         in_grant_o  <= 1'b0;
         err_o       <= 1'b0;
         err_count_o <= '0;
      end else begin
         count       <= count_n;
         out_data_o  <= s0;
         b1          <= s1;
         out_valid_o <= count_n != 2'd0;
         in_grant_o  <= (count_n < 2'd2) && run_ok;
         err_o       <= bad;
         err_count_o <= cnt_n;
      end
   end
endmodule

// File: tb/tb_fifo_parity_checker.sv
// tb_fifo_parity_checker: scoreboard bench with a transaction-level model of the parity checker.
module tb_fifo_parity_checker;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid_i;
   logic [8:0] in_data_i;
   logic       in_grant_o;
   logic       out_valid_o;
   logic [7:0] out_data_o;
   logic       out_grant_i;
   logic       err_o;
   logic [1:0] err_count_o;
   logic       clr_err_i;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sbq[$];
   int         mcnt, mec;
   bit         mgrant, mhalt;

   fifo_parity_checker #(.DATA_WIDTH(8), .ODD_PARITY(0), .ERR_CNT_WIDTH(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_grant_o(in_grant_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_grant_i(out_grant_i),
      .err_o(err_o), .err_count_o(err_count_o), .clr_err_i(clr_err_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mcnt = 0; mec = 0; mgrant = 0; mhalt = 0;
      sbq.delete();
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_grant"}, in_grant_o, 0);
      chk({nm, "_valid"}, out_valid_o, 0);
      chk({nm, "_data"}, out_data_o, 0);
      chk({nm, "_err"}, err_o, 0);
      chk({nm, "_cnt"}, err_count_o, 0);
   endtask

   // one clock of stimulus; the model advances by the handshake rules and the DUT is compared after the edge
   task automatic step(input logic v, input logic [8:0] d, input logic og, input logic clr);
      bit acc, good, pop, merr, old;
      in_valid_i = v; in_data_i = d; out_grant_i = og; clr_err_i = clr;
      @(posedge clk); #1;
      acc  = v && mgrant;
      good = ($countones(d) % 2) == 0;
      pop  = (mcnt != 0) && og;
      if (acc && good) sbq.push_back(d[7:0]);
      mcnt = mcnt + ((acc && good) ? 1 : 0) - (pop ? 1 : 0);
      merr = acc && !good;
      if (clr) mec = 0;
      if (merr && mec < 3) mec++;
      old = mhalt;
`ifdef PARITY_CHK_HALT_EN
      if (merr) mhalt = 1;
      else if (clr) mhalt = 0;
`endif
      mgrant = (mcnt < 2) && !mhalt && !old;
      chk("in_grant", in_grant_o, mgrant);
      chk("out_valid", out_valid_o, mcnt != 0);
      chk("err_pulse", err_o, merr);
      chk("err_count", err_count_o, mec);
      #1;
   endtask

   // the head must match the oldest expected payload whenever it is presented, and leaves only on a grant
   always @(negedge clk) begin
      if (reset_n && out_valid_o) begin
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_unexpected: got word %0h expected none", out_data_o);
         end else begin
            chk("out_data", out_data_o, sbq[0]);
            if (out_grant_i) void'(sbq.pop_front());
         end
      end
   end

   initial begin
      reset_n = 1'b0; in_valid_i = 1'b1; in_data_i = 9'h003; out_grant_i = 1'b1; clr_err_i = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      #1 reset_n = 1'b1;
      step(0, 9'h000, 1, 0);
      chk("grant_after_release", in_grant_o, 1);
      // good stream
      step(1, 9'h003, 1, 0);
      step(1, 9'h107, 1, 0);
      step(1, 9'h0FF, 1, 0);
      repeat (2) step(0, 9'h000, 1, 0);
      chk("stream_cnt", err_count_o, 0);
`ifndef PARITY_CHK_HALT_EN
      // bad word between good words
      step(1, 9'h003, 1, 0);
      step(1, 9'h007, 1, 0);
      step(1, 9'h107, 1, 0);
      chk("bad_cnt", err_count_o, 1);
      repeat (2) step(0, 9'h000, 1, 0);
      step(0, 9'h000, 1, 1);
`endif
      // backpressure
      step(1, 9'h003, 0, 0);
      step(1, 9'h107, 0, 0);
      step(1, 9'h0FF, 0, 0);
      step(1, 9'h0FF, 0, 0);
      chk("bp_grant", in_grant_o, 0);
      chk("bp_head", out_data_o, 8'h03);
      step(1, 9'h0FF, 1, 0);
      step(1, 9'h0FF, 1, 0);
      repeat (3) step(0, 9'h000, 1, 0);
`ifndef PARITY_CHK_HALT_EN
      // saturation and clear-with-error
      repeat (5) step(1, 9'h007, 1, 0);
      chk("sat_cnt", err_count_o, 3);
      step(1, 9'h007, 1, 1);
      chk("clr_err_cnt", err_count_o, 1);
`else
      step(1, 9'h001, 1, 0);
      chk("halt_err", err_o, 1);
      step(1, 9'h003, 1, 0);
      chk("halt_grant", in_grant_o, 0);
      step(1, 9'h003, 1, 1);
      chk("halt_clr_cnt", err_count_o, 0);
      step(1, 9'h003, 1, 0);
      chk("halt_resume", in_grant_o, 1);
`endif
      // randomized traffic with one mid-run reset
      for (int i = 0; i < 800; i++) begin
         if (i == 400) begin
            reset_n = 1'b0;
            #1 chk_zero("midreset");
            model_reset();
            #1 reset_n = 1'b1;
         end
         step($urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      end
      repeat (4) step(0, 9'h000, 1, 0);
      chk("sb_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
